// File: rtl/bg_blitter.sv
// rtl/bg_blitter.sv - raster-order frame fill from an image ROM into a pixel-write port
//
// Purpose: when started, walks every pixel of a WIDTH x HEIGHT image ROM in raster order and
// emits x, y, colour and a plot strobe, one pixel per cycle. ROM read latency is ROM_LAT (1 or 2).
// Optional feature macro: BLIT_TRANSPARENT_EN (pixels whose colour equals TRANSP_KEY are not plotted).
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, abort      1-cycle fill request (IDLE only) / stop the current fill
//   rom_addr, rom_q   ROM address (y*WIDTH + x) and ROM data (ROM_LAT cycles later)
//   x, y, colour      registered pixel position and colour
//   plot              one pixel written per high cycle
//   busy, done        fill in progress / 1-cycle pulse after the final plot

module bg_blitter #(
  parameter int                      WIDTH      = 160,
  parameter int                      HEIGHT     = 120,
  parameter int                      X_W        = 8,
  parameter int                      Y_W        = 8,
  parameter int                      ADDR_W     = 15,
  parameter int                      COLOUR_W   = 12,
  parameter int                      ROM_LAT    = 1,
  parameter logic [COLOUR_W-1:0]     TRANSP_KEY = 12'h0F0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [X_W-1:0] gx;
  logic [Y_W-1:0] gy;

  // Valid bit and pixel position travelling alongside the ROM read.
  logic           v_pipe  [ROM_LAT];
  logic [X_W-1:0] gx_pipe [ROM_LAT];
  logic [Y_W-1:0] gy_pipe [ROM_LAT];

  logic last_addr;
  logic pipe_busy;
  logic accept;
  logic issue;
  logic keep;

  assign last_addr = (rom_addr == LAST_ADDR);
  assign accept    = (state == IDLE) && start && !abort;
  assign issue     = (state == FILL) && !abort;

`ifdef BLIT_TRANSPARENT_EN
  assign keep = (rom_q != TRANSP_KEY);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) pipe_busy = pipe_busy | v_pipe[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = FILL;
      FILL:    if (abort) state_nxt = IDLE;
               else if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (!pipe_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      gx       <= '0;
      gy       <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
        v_pipe[i]  <= 1'b0;
        gx_pipe[i] <= '0;
        gy_pipe[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      // Counters hold on the last address so nothing out of range is ever presented.
      if (accept) begin
        rom_addr <= '0;
        gx       <= '0;
        gy       <= '0;
      end else if (issue && !last_addr) begin
        rom_addr <= rom_addr + ADDR_W'(1);
        if (gx == LAST_X) begin
          gx <= '0;
          gy <= gy + Y_W'(1);
        end else begin
          gx <= gx + X_W'(1);
        end
      end

      v_pipe[0]  <= issue;
      gx_pipe[0] <= gx;
      gy_pipe[0] <= gy;
      for (int i = 1; i < ROM_LAT; i++) begin
        v_pipe[i]  <= v_pipe[i-1] && !abort;
        gx_pipe[i] <= gx_pipe[i-1];
        gy_pipe[i] <= gy_pipe[i-1];
      end

      // Abort discards whatever is in flight, including the pixel at the output stage.
      plot <= v_pipe[ROM_LAT-1] && keep && !abort;
      if (v_pipe[ROM_LAT-1] && keep && !abort) begin
        x      <= gx_pipe[ROM_LAT-1];
        y      <= gy_pipe[ROM_LAT-1];
        colour <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_bg_blitter.sv
// tb/tb_bg_blitter.sv - scoreboard bench for bg_blitter at ROM_LAT 1 and 2

module tb_bg_blitter;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam logic [11:0] KEY = 12'd5;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [7:0] y;
    logic [11:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [14:0] rom_addr [2];
  logic [11:0] rom_q    [2];
  logic [7:0]  xo       [2];
  logic [7:0]  yo       [2];
  logic [11:0] colour   [2];
  logic        plot     [2];
  logic        busy     [2];
  logic        done     [2];

  logic [11:0] rom_q2_s1;

  pix_t exp_q  [2][$];
  int   done_q [2][$];
  int   busy_lo [2];
  int   busy_hi [2];
  int   idle_from [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bg_blitter #(.WIDTH(W), .HEIGHT(H), .ROM_LAT(1), .TRANSP_KEY(KEY)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr[0]), .rom_q(rom_q[0]), .x(xo[0]), .y(yo[0]), .colour(colour[0]),
    .plot(plot[0]), .busy(busy[0]), .done(done[0]));

  bg_blitter #(.WIDTH(W), .HEIGHT(H), .ROM_LAT(2), .TRANSP_KEY(KEY)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr[1]), .rom_q(rom_q[1]), .x(xo[1]), .y(yo[1]), .colour(colour[1]),
    .plot(plot[1]), .busy(busy[1]), .done(done[1]));

  // ROM models: q = address, with 1 and 2 cycles of read latency.
  always @(posedge clk) begin
    rom_q[0]  <= rom_addr[0][11:0];
    rom_q2_s1 <= rom_addr[1][11:0];
    rom_q[1]  <= rom_q2_s1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: a started frame yields N pixels in raster order, pixel k plotted at
  // start + k + lat + 2, done at start + N + lat + 2; abort while busy cancels the rest.
  task automatic model(input int t, input bit st, input bit ab);
    for (int d = 0; d < 2; d++) begin
      int lat = d + 1;
      if (ab && t >= busy_lo[d] && t < busy_hi[d]) begin
        while (exp_q[d].size() > 0 && exp_q[d][$].cyc > t) void'(exp_q[d].pop_back());
        done_q[d].delete();
        busy_hi[d]   = t + 1;
        idle_from[d] = t + 1;
      end else if (st && !ab && t >= idle_from[d]) begin
        for (int k = 0; k < N; k++) begin
          pix_t p;
          p.cyc = t + k + lat + 2;
          p.x   = 8'(k % W);
          p.y   = 8'(k / W);
          p.c   = 12'(k);
`ifdef BLIT_TRANSPARENT_EN
          if (p.c != KEY) exp_q[d].push_back(p);
`else
          exp_q[d].push_back(p);
`endif
        end
        done_q[d].push_back(t + N + lat + 2);
        busy_lo[d]   = t + 1;
        busy_hi[d]   = t + N + lat + 2;
        idle_from[d] = t + N + lat + 3;
      end
    end
  endtask

  task automatic drive(input bit st, input bit ab);
    @(posedge clk);
    #1;
    start = st;
    abort = ab;
    model(cyc, st, ab);
  endtask

  // Monitor: compares every cycle against whatever the scoreboard expects at this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        bit exp_plot;
        bit exp_done;
        exp_plot = (exp_q[d].size() > 0) && (exp_q[d][0].cyc == cyc);
        exp_done = (done_q[d].size() > 0) && (done_q[d][0] == cyc);
        check($sformatf("plot[lat%0d]", d + 1), 32'(plot[d]), 32'(exp_plot));
        if (exp_plot) begin
          pix_t p;
          p = exp_q[d].pop_front();
          if (plot[d])
            check($sformatf("pixel{x,y,c}[lat%0d]", d + 1),
                  {4'd0, xo[d], yo[d], colour[d]}, {4'd0, p.x, p.y, p.c});
        end
        check($sformatf("done[lat%0d]", d + 1), 32'(done[d]), 32'(exp_done));
        if (exp_done) void'(done_q[d].pop_front());
        check($sformatf("busy[lat%0d]", d + 1), 32'(busy[d]),
              32'(cyc >= busy_lo[d] && cyc < busy_hi[d]));
      end
    end
  end

  initial begin
    int s;
    for (int d = 0; d < 2; d++) begin
      busy_lo[d] = 0;
      busy_hi[d] = 0;
      idle_from[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) drive(0, 0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset rom_addr", 32'(rom_addr[d]), 32'd0);
      check("reset x", 32'(xo[d]), 32'd0);
      check("reset y", 32'(yo[d]), 32'd0);
      check("reset colour", 32'(colour[d]), 32'd0);
    end

    // Plain frame.
    drive(1, 0);
    repeat (20) drive(0, 0);

    // Second start on the cycle after the 5th plot (ROM_LAT=1 timing): ignored.
    drive(1, 0);
    s = cyc;
    while (cyc < s + 6) drive(0, 0);
    drive(1, 0);
    repeat (15) drive(0, 0);

    // Abort on the cycle after the 6th plot, then a fresh frame.
    drive(1, 0);
    s = cyc;
    while (cyc < s + 7) drive(0, 0);
    drive(0, 1);
    repeat (3) drive(0, 0);
    drive(1, 0);
    repeat (20) drive(0, 0);

    // Start and abort together in IDLE: abort wins.
    drive(1, 1);
    repeat (5) drive(0, 0);

    // Random start/abort traffic.
    repeat (3000) drive($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    repeat (40) drive(0, 0);

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("pixels outstanding", 32'(exp_q[d].size()), 32'd0);
      check("done outstanding", 32'(done_q[d].size()), 32'd0);
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
